// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope capture block.
// Contents: capture FSM state encoding, trig_mode codes, readout latency.
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  localparam logic [1:0] TM_RISE   = 2'b00;
  localparam logic [1:0] TM_FALL   = 2'b01;
  localparam logic [1:0] TM_EITHER = 2'b10;
  localparam logic [1:0] TM_AUTO   = 2'b11;

  // Capture buffer read latency in cycles, absorbed by the output skid stage.
  localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/osc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a
// 1-cycle registered read. Contents are never reset.
// Ports:
//   clk              - clock
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr    - read request; rd_data valid the cycle after rd_en
module osc_capture_ram #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned ASIZE = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/osc_capture_core.sv
// Triggered multi-channel capture: keeps decimated frames in a circular
// buffer around a trigger event, then streams DEPTH frames out.
// Ports:
//   CLK100MHz, rst_n           - clock, synchronous active-low reset
//   smp_valid, smp_data        - incoming frames (channel k at [k*DSIZE +: DSIZE])
//   arm, abort                 - start capture / return to IDLE
//   trig_src/mode/level        - trigger channel, edge mode, unsigned threshold
//   pretrig_len, decim         - frames kept before trigger, decimation ratio-1
//   rd_valid/ready/data/last   - readout stream
//   state_o, trig_seen, done, overrun - status
module osc_capture_core
  import osc_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DSIZE = 12,
  parameter int unsigned ASIZE = 10
) (
  input  logic                 CLK100MHz,
  input  logic                 rst_n,
  input  logic                 smp_valid,
  input  logic [NCH*DSIZE-1:0] smp_data,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [1:0]           trig_src,
  input  logic [1:0]           trig_mode,
  input  logic [DSIZE-1:0]     trig_level,
  input  logic [ASIZE-1:0]     pretrig_len,
  input  logic [7:0]           decim,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [NCH*DSIZE-1:0] rd_data,
  output logic                 rd_last,
  output logic [2:0]           state_o,
  output logic                 trig_seen,
  output logic                 done,
  output logic                 overrun
);

  localparam int unsigned W     = NCH * DSIZE;
  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] LAST_IDX = (ASIZE+1)'(DEPTH - 1);

  state_t state, state_nx;

  logic [7:0]       dcnt, decim_q;
  logic [ASIZE-1:0] pre_q, pre_cnt, post_cnt, wr_ptr, trig_addr, rd_addr;
  logic [ASIZE:0]   iss_cnt;
  logic [DSIZE-1:0] prev, cur_c;
  logic             prev_vld;

  logic             capturing_c, kept_c, trig_hit_c, rise_c, fall_c, edge_c;
  logic [ASIZE-1:0] post_tgt_c;

  logic             q_vld, q_last, skid_vld, skid_last;
  logic [W-1:0]     q_data, skid_data;
  logic             pop_c, issue_c;
  logic [1:0]       occ_c;

  // Frame acceptance and decimation
  always_comb begin
    capturing_c = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
    kept_c      = capturing_c && smp_valid && (dcnt == decim_q);
    // DEPTH-1-pretrig; pretrig_len is ASIZE bits so it never exceeds DEPTH-1
    post_tgt_c  = ~pre_q;
  end

  // Trigger channel select and edge detect
  always_comb begin
    cur_c = smp_data[DSIZE-1:0];
    for (int unsigned k = 0; k < NCH; k++) begin
      if (trig_src == 2'(k)) cur_c = smp_data[k*DSIZE +: DSIZE];
    end
    rise_c = (prev < trig_level) && (cur_c >= trig_level);
    fall_c = (prev >= trig_level) && (cur_c < trig_level);
    case (trig_mode)
      TM_RISE:   edge_c = rise_c;
      TM_FALL:   edge_c = fall_c;
      TM_EITHER: edge_c = rise_c || fall_c;
      default:   edge_c = 1'b1;
    endcase
    // prev_vld gates out the first kept frame after arm in every mode
    trig_hit_c = (state == ST_ARMED) && kept_c && prev_vld && edge_c;
  end

  // Readout issue: keep out + skid + in-flight RAM word within two slots
  always_comb begin
    pop_c   = rd_valid && rd_ready;
    occ_c   = {1'b0, rd_valid} + {1'b0, skid_vld} + {1'b0, q_vld};
    issue_c = (state == ST_READ) && !abort && !iss_cnt[ASIZE] &&
              ((occ_c - {1'b0, pop_c}) < 2'd2);
  end

  // FSM state register
  always_ff @(posedge CLK100MHz) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arm) state_nx = (pretrig_len == '0) ? ST_ARMED : ST_PRE;
      ST_PRE:   if (kept_c && (pre_cnt == pre_q - ASIZE'(1))) state_nx = ST_ARMED;
      ST_ARMED: if (trig_hit_c) state_nx = (post_tgt_c == '0) ? ST_READ : ST_POST;
      ST_POST:  if (kept_c && (post_cnt == post_tgt_c - ASIZE'(1))) state_nx = ST_READ;
      ST_READ:  if (pop_c && rd_last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  assign state_o = state;

  // Capture datapath, readout pipeline and status
  always_ff @(posedge CLK100MHz) begin
    if (!rst_n) begin
      dcnt      <= '0;
      decim_q   <= '0;
      pre_q     <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      trig_addr <= '0;
      rd_addr   <= '0;
      iss_cnt   <= '0;
      prev      <= '0;
      prev_vld  <= 1'b0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      trig_seen <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else if (abort) begin
      // Frame kept in this cycle is dropped; readout is flushed
      q_vld     <= 1'b0;
      skid_vld  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      trig_seen <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if ((state == ST_IDLE) && arm) begin
        dcnt      <= '0;
        decim_q   <= decim;
        pre_q     <= pretrig_len;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        prev_vld  <= 1'b0;
        trig_seen <= 1'b0;
        overrun   <= 1'b0;
      end

      if (capturing_c && smp_valid) dcnt <= kept_c ? 8'd0 : dcnt + 8'd1;

      if (kept_c) begin
        wr_ptr <= wr_ptr + ASIZE'(1);
        if (state != ST_POST) begin
          prev     <= cur_c;
          prev_vld <= 1'b1;
        end
        if (state == ST_PRE)  pre_cnt  <= pre_cnt + ASIZE'(1);
        if (state == ST_POST) post_cnt <= post_cnt + ASIZE'(1);
      end

      if (trig_hit_c) begin
        trig_addr <= wr_ptr;
        trig_seen <= 1'b1;
      end

      // Oldest frame sits pre_q slots before the trigger frame
      if ((state != ST_READ) && (state_nx == ST_READ)) begin
        rd_addr <= (trig_hit_c ? wr_ptr : trig_addr) - pre_q;
        iss_cnt <= '0;
      end else if (issue_c) begin
        rd_addr <= rd_addr + ASIZE'(1);
        iss_cnt <= iss_cnt + (ASIZE+1)'(1);
      end

      if ((state == ST_READ) && smp_valid) overrun <= 1'b1;

      q_vld  <= issue_c;
      q_last <= (iss_cnt == LAST_IDX);

      if (!rd_valid || pop_c) begin
        if (skid_vld) begin
          rd_valid  <= 1'b1;
          rd_data   <= skid_data;
          rd_last   <= skid_last;
          skid_vld  <= q_vld;
          skid_data <= q_data;
          skid_last <= q_last;
        end else if (q_vld) begin
          rd_valid <= 1'b1;
          rd_data  <= q_data;
          rd_last  <= q_last;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end else if (q_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= q_data;
        skid_last <= q_last;
      end

      if (pop_c && rd_last) done <= 1'b1;
    end
  end

  osc_capture_ram #(
    .WIDTH (W),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk     (CLK100MHz),
    .wr_en   (kept_c && !abort),
    .wr_addr (wr_ptr),
    .wr_data (smp_data),
    .rd_en   (issue_c),
    .rd_addr (rd_addr),
    .rd_data (q_data)
  );

endmodule
